// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_pkg
// Brief    : Shared types and constants for the machine interrupt source.
// Revision : 1.0 - initial release
// ============================================================================
package irq_pkg;

    typedef enum logic [1:0] {
        IRQ_NONE = 2'd0,
        IRQ_EXT  = 2'd1,
        IRQ_SW   = 2'd2,
        IRQ_TIM  = 2'd3
    } irq_code_t;

    // Byte offsets inside the 16-byte register window
    localparam logic [3:0] C_OFF_MTIME    = 4'h0;
    localparam logic [3:0] C_OFF_MTIMECMP = 4'h4;
    localparam logic [3:0] C_OFF_CTRL     = 4'h8;
    localparam logic [3:0] C_OFF_PEND     = 4'hC;

    localparam int C_CTRL_TIM_EN       = 0;
    localparam int C_CTRL_EXT_EN       = 1;
    localparam int C_CTRL_SW_EN        = 2;
    localparam int C_CTRL_PRESCALE_LSB = 8;

    localparam int C_PEND_TIM = 0;
    localparam int C_PEND_EXT = 1;
    localparam int C_PEND_SW  = 2;

    localparam logic [31:0] C_MTIMECMP_RST = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/irq_timer.sv
`default_nettype none
// ============================================================================
// Module   : irq_timer
// Brief    : Prescaled 32-bit mtime counter with mtimecmp compare.
// Revision : 1.0 - initial release
// ============================================================================
module irq_timer
    import irq_pkg::*;
#(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  mtime_wr,
    input  logic                  mtimecmp_wr,
    input  logic [31:0]           wdata,
    output logic [31:0]           mtime,
    output logic [31:0]           mtimecmp,
    output logic                  tim_hit
);

    logic [PRESCALE_W-1:0] r_pre_cnt;
    logic [31:0]           r_mtime;
    logic [31:0]           r_mtimecmp;
    logic                  w_tick;

    // >= rather than == so that lowering prescale mid-count cannot strand the counter
    assign w_tick = (r_pre_cnt >= prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre_cnt  <= '0;
            r_mtime    <= '0;
            r_mtimecmp <= C_MTIMECMP_RST;
        end else begin
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRESCALE_W'(1);
            if (mtime_wr)
                r_mtime <= wdata;
            else if (w_tick)
                r_mtime <= r_mtime + 32'd1;
            if (mtimecmp_wr)
                r_mtimecmp <= wdata;
        end
    end

    assign mtime    = r_mtime;
    assign mtimecmp = r_mtimecmp;
    assign tim_hit  = (r_mtime >= r_mtimecmp);

endmodule
`default_nettype wire

// File: rtl/irq_source_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_source_ctrl
// Brief    : Machine timer/external/software interrupt source with trap handshake.
// Revision : 1.0 - initial release
// ============================================================================
module irq_source_ctrl
    import irq_pkg::*;
#(
    parameter int          PRESCALE_W = 8,
    parameter logic [11:0] BASE_ADDR  = 12'h800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] addr,
    input  logic [31:0] wdata,
    input  logic        reg_wr,
    input  logic        reg_rd,
    output logic [31:0] rdata,
    input  logic        ext_irq,
    input  logic        irq_ack,
    input  logic        is_mret,
    output logic [1:0]  interrupt,
    output logic        in_service
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } svc_state_t;

    svc_state_t            r_state;
    logic                  r_in_service;
    logic                  r_tim_en, r_ext_en, r_sw_en;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_sync1, r_sync2, r_sync3;
    logic                  r_ext_p, r_sw_p;

    logic                  w_win;
    logic                  w_wr_mtime, w_wr_mtimecmp, w_wr_ctrl, w_wr_pend;
    logic [31:0]           w_mtime, w_mtimecmp;
    logic                  w_tim_hit;
    logic                  w_ext_edge;
    logic                  w_ack_ext, w_ack_sw;
    irq_code_t             w_irq;
    logic [31:0]           w_ctrl_rd, w_pend_rd, w_rdata;

    assign w_win         = (addr[11:4] == BASE_ADDR[11:4]);
    assign w_wr_mtime    = reg_wr && w_win && (addr[3:0] == C_OFF_MTIME);
    assign w_wr_mtimecmp = reg_wr && w_win && (addr[3:0] == C_OFF_MTIMECMP);
    assign w_wr_ctrl     = reg_wr && w_win && (addr[3:0] == C_OFF_CTRL);
    assign w_wr_pend     = reg_wr && w_win && (addr[3:0] == C_OFF_PEND);

    irq_timer #(
        .PRESCALE_W (PRESCALE_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .prescale    (r_prescale),
        .mtime_wr    (w_wr_mtime),
        .mtimecmp_wr (w_wr_mtimecmp),
        .wdata       (wdata),
        .mtime       (w_mtime),
        .mtimecmp    (w_mtimecmp),
        .tim_hit     (w_tim_hit)
    );

    assign w_ext_edge = r_sync2 && !r_sync3;
    assign w_ack_ext  = irq_ack && (w_irq == IRQ_EXT);
    assign w_ack_sw   = irq_ack && (w_irq == IRQ_SW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tim_en   <= 1'b0;
            r_ext_en   <= 1'b0;
            r_sw_en    <= 1'b0;
            r_prescale <= '0;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync3    <= 1'b0;
            r_ext_p    <= 1'b0;
            r_sw_p     <= 1'b0;
        end else begin
            r_sync1 <= ext_irq;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (w_wr_ctrl) begin
                r_tim_en   <= wdata[C_CTRL_TIM_EN];
                r_ext_en   <= wdata[C_CTRL_EXT_EN];
                r_sw_en    <= wdata[C_CTRL_SW_EN];
                r_prescale <= wdata[C_CTRL_PRESCALE_LSB +: PRESCALE_W];
            end
            // A new edge outranks any clear landing in the same cycle
            r_ext_p <= w_ext_edge ||
                       (r_ext_p && !w_ack_ext && !(w_wr_pend && wdata[C_PEND_EXT]));
            if (w_wr_pend)
                r_sw_p <= wdata[C_PEND_SW];
            else if (w_ack_sw)
                r_sw_p <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_in_service <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (irq_ack && (w_irq != IRQ_NONE)) begin
                        r_state      <= ST_SERVICE;
                        r_in_service <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (is_mret) begin
                        r_state      <= ST_IDLE;
                        r_in_service <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_in_service <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_irq = IRQ_NONE;
        if (!rst && !r_in_service) begin
            if (r_ext_p && r_ext_en)
                w_irq = IRQ_EXT;
            else if (r_sw_p && r_sw_en)
                w_irq = IRQ_SW;
            else if (w_tim_hit && r_tim_en)
                w_irq = IRQ_TIM;
        end
    end

    always_comb begin
        w_ctrl_rd                                          = '0;
        w_ctrl_rd[C_CTRL_TIM_EN]                           = r_tim_en;
        w_ctrl_rd[C_CTRL_EXT_EN]                           = r_ext_en;
        w_ctrl_rd[C_CTRL_SW_EN]                            = r_sw_en;
        w_ctrl_rd[C_CTRL_PRESCALE_LSB +: PRESCALE_W]       = r_prescale;
        w_pend_rd                                          = '0;
        w_pend_rd[C_PEND_TIM]                              = w_tim_hit;
        w_pend_rd[C_PEND_EXT]                              = r_ext_p;
        w_pend_rd[C_PEND_SW]                               = r_sw_p;
    end

    always_comb begin
        w_rdata = '0;
        if (reg_rd && w_win && !rst) begin
            case (addr[3:0])
                C_OFF_MTIME:    w_rdata = w_mtime;
                C_OFF_MTIMECMP: w_rdata = w_mtimecmp;
                C_OFF_CTRL:     w_rdata = w_ctrl_rd;
                C_OFF_PEND:     w_rdata = w_pend_rd;
                default:        w_rdata = '0;
            endcase
        end
    end

    assign rdata      = w_rdata;
    assign interrupt  = w_irq;
    assign in_service = r_in_service;

endmodule
`default_nettype wire

// File: doc/irq_source_ctrl.md
Name: irq_source_ctrl

Overview:
- Machine-level interrupt source feeding the CSR register file's interrupt input, and the initiator side of the trap handshake.
- Owns a memory-mapped 32-bit machine timer (mtime/mtimecmp), a synchronized external interrupt line and a software interrupt bit.
- Prioritises pending sources and presents one 2-bit interrupt code to the core.
- Holds further requests off from trap acknowledge until the core executes mret.

Parameters:
- PRESCALE_W, 8, width of the timer prescaler field and counter.
- BASE_ADDR, 12'h800, base of the 4-word register window on the core's addr bus.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- addr  in  12  register address (word-aligned, core CSR/MMIO address bus).
- wdata  in  32  write data.
- reg_wr  in  1  write strobe, single cycle.
- reg_rd  in  1  read strobe.
- rdata  out  32  read data, combinational; 0 when reg_rd=0 or address misses the window.
- ext_irq  in  1  asynchronous external interrupt line.
- irq_ack  in  1  core took the trap this cycle (CSR file epc_taken with non-mret cause).
- is_mret  in  1  core retiring mret this cycle.
- interrupt  out  2  interrupt code to core: 0 none, 1 external, 2 software, 3 timer.
- in_service  out  1  trap being handled; requests masked.

Behaviour:
- Reset (async, rst=1): mtime=0, mtimecmp=32'hFFFF_FFFF, CTRL=0, prescale counter=0, ext/sw pending=0, sync flops=0, in_service=0. interrupt=0, rdata=0 while asserted. Reset mid-trap drops all state; no mret required afterwards.
- Register map, offsets from BASE_ADDR:
  - +0 MTIME: R/W.
  - +4 MTIMECMP: R/W.
  - +8 CTRL: bit0 tim_en, bit1 ext_en, bit2 sw_en, bits[8+PRESCALE_W-1:8] prescale; other bits read 0.
  - +12 PEND: read bit0 tim_p, bit1 ext_p, bit2 sw_p. Write: bit1=1 clears ext_p; bit2 writes sw_p (set or clear).
- Timer:
  - Prescale counter increments each cycle; on reaching CTRL.prescale it returns to 0 and mtime increments. prescale=0 means mtime increments every cycle.
  - mtime wraps 32'hFFFF_FFFF→0, unsigned, no sticky flag.
  - A write to MTIME in the same cycle as an increment wins; the written value appears next cycle.
  - tim_p = (mtime >= mtimecmp), unsigned, level-sensitive. It is cleared only by software raising mtimecmp or by mtime wrap; irq_ack does not clear it.
- External line:
  - Two-flop synchronizer, then rising-edge detect against a third flop.
  - ext_p is set on a detected edge, clears on irq_ack while interrupt=1, or by PEND write.
  - Edge and clear in the same cycle: set wins.
  - Latency: line high before clk edge n → ext_p=1 after edge n+2 → interrupt=1 in that cycle (combinational from pending).
- Software: sw_p is cleared on irq_ack while interrupt=2. A PEND write setting bit2 in the same cycle as the ack: set wins.
- Arbitration (combinational): if in_service=1 then interrupt=0. Otherwise the first enabled pending source in order ext(1) > sw(2) > tim(3); else 0.
- Handshake:
  - interrupt holds steady until irq_ack. irq_ack while interrupt=0 is ignored.
  - irq_ack with interrupt≠0: in_service←1 next edge; the acked source's edge-pending clears.
  - is_mret while in_service: in_service←0; the next pending source may be presented the following cycle.
  - is_mret while not in service: ignored.
  - irq_ack and is_mret in the same cycle: ack wins, in_service stays 1.
- Writes outside the window are ignored; reads outside the window return 0.

Decomposition:
- Shared package irq_pkg: irq_code_t enum (IRQ_NONE=0, IRQ_EXT=1, IRQ_SW=2, IRQ_TIM=3), register offset constants, CTRL bit indices, MTIMECMP reset constant.
- One sub-module, irq_timer: prescaler, mtime, mtimecmp and compare, with write ports. Synchronizer, pending logic, arbiter and handshake FSM (IDLE/SERVICE) stay in the top.

Test Plan:
- Reset then read: rst pulse → MTIME=0, MTIMECMP=FFFF_FFFF, CTRL=0, PEND=0, interrupt=0, in_service=0.
- Timer fire: CTRL=1 (prescale 0), MTIMECMP=10, MTIME=0 → interrupt=3 the cycle mtime reaches 10. Ack → in_service=1, interrupt=0. Write MTIMECMP=FFFF_FFFF, then mret → in_service=0, interrupt=0.
- External edge: CTRL=2, ext_irq 0→1 → interrupt=1 exactly 3 edges later. Hold line high after ack+mret → no second request (edge, not level).
- Priority and masking: CTRL=7, tim_p and sw_p set, then an ext edge → interrupt=1. Ack, mret → interrupt=2. Ack, mret → interrupt=3. Ack with CTRL=0 → no request.
- Prescale and wrap: prescale=3, MTIME=FFFF_FFFE → MTIME=0 after 8 cycles. Write MTIME in the increment cycle → written value retained.
- Collisions: ext edge in the irq_ack cycle for ext → ext_p stays 1, interrupt=1 after mret. Async rst during in_service → all outputs 0 immediately.
